// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_ctrl_if : ROM, redirect and decode-handshake signals of fetch_ctrl.
// Rev 1.0
// ============================================================================
interface fetch_ctrl_if #(
  parameter int N = 64
);
  logic [6:0]   imem_addr;
  logic [31:0]  imem_q;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instr;
  logic [N-1:0] out_pc;
  logic         halted;

  modport master (
    output imem_addr,
    input  imem_q,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : PC sequencer feeding a 2-entry {pc, instr} buffer to decode.
// Optional FETCH_HALT_EN: stop fetching after CBZ XZR,#0.   Rev 1.0
// ============================================================================
module fetch_ctrl #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

`ifdef FETCH_HALT_EN
  localparam logic [31:0] c_HALT_INSN = 32'hb400001f;
`endif

  state_e       state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]   count_q, count_d;
  logic [N-1:0] pc_q [2];
  logic [N-1:0] pc_d [2];
  logic [31:0]  instr_q [2];
  logic [31:0]  instr_d [2];

  logic w_pop;
  logic w_push;
  logic w_slot;

  assign w_pop  = (count_q != 2'd0) && bus.out_ready;
  assign w_push = !bus.redirect_valid && (state_q == ST_FETCH) &&
                  ((count_q != 2'd2) || w_pop);
  // Push lands just behind whatever survives this cycle's pop.
  assign w_slot = count_q[1] | (count_q[0] & ~w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if (bus.redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = bus.redirect_pc;
      state_d    = ST_FETCH;
    end else begin
      if (w_pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (w_push) begin
        pc_d[w_slot]    = fetch_pc_q;
        instr_d[w_slot] = bus.imem_q;
        fetch_pc_d      = fetch_pc_q + N'(4);
`ifdef FETCH_HALT_EN
        if (bus.imem_q == c_HALT_INSN) begin
          state_d = ST_HALT;
        end
`endif
      end
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.imem_addr = fetch_pc_q[8:2];
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = bus.out_valid ? instr_q[0] : 32'd0;
  assign bus.out_pc    = bus.out_valid ? pc_q[0] : '0;

`ifdef FETCH_HALT_EN
  assign bus.halted = (state_q == ST_HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : scoreboard bench for fetch_ctrl (N=64, RESET_PC=0).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_ctrl;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

`ifdef FETCH_HALT_EN
  localparam logic c_HALT_ON = 1'b1;
`else
  localparam logic c_HALT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  ent_t exp_q[$];
  ent_t e;

  fetch_ctrl_if #(.N(64)) bus ();

  fetch_ctrl #(.N(64), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [6:0] a);
    case (a)
      7'd0:    rom = 32'hf8000001;
      7'd1:    rom = 32'hf8008002;
      7'd2:    rom = 32'hf8000203;
      7'd28:   rom = 32'hf807801f;
      7'd29:   rom = 32'hb4000040;
      7'd46:   rom = 32'hb400001f;
      7'd127:  rom = 32'h00000000;
      default: rom = 32'h11000000 | {25'd0, a};
    endcase
  endfunction

  always_comb bus.imem_q = rom(bus.imem_addr);

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h70;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b need 0", bus.out_valid); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b need 0", bus.halted); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h need 0", bus.out_instr); end
    total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL rst_pc: got %h need 0", bus.out_pc); end
    total++; if (bus.imem_addr !== 7'd0) begin bad++; $display("FAIL rst_addr: got %0d need 0", bus.imem_addr); end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    exp_q.delete();
    exp_q.push_back('{64'h0, 32'hf8000001});
    exp_q.push_back('{64'h4, 32'hf8008002});
    exp_q.push_back('{64'h8, 32'hf8000203});
    exp_q.push_back('{64'hc, rom(7'd3)});
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL stream_valid[%0d]: got %b need 1 (pending %0d)", i, bus.out_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          bad++; $display("FAIL stream_head[%0d]: got pc=%h instr=%h need pc=%h instr=%h", i, bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_left: got %0d need 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b need 1", bus.out_valid); end
    total++; if (bus.imem_addr !== 7'd2) begin bad++; $display("FAIL bp_addr: got %0d need 2", bus.imem_addr); end
    total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL bp_pc: got %h need 0", bus.out_pc); end
    exp_q.delete();
    exp_q.push_back('{64'h0, 32'hf8000001});
    exp_q.push_back('{64'h4, 32'hf8008002});
    exp_q.push_back('{64'h8, 32'hf8000203});
    exp_q.push_back('{64'hc, rom(7'd3)});
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL bp_drain_valid[%0d]: got %b need 1 (pending %0d)", i, bus.out_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          bad++; $display("FAIL bp_drain_head[%0d]: got pc=%h instr=%h need pc=%h instr=%h", i, bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    // Buffer full; the head still completes its handshake in the redirect cycle.
    exp_q.delete();
    exp_q.push_back('{64'h0, 32'hf8000001});
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h70;
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
      bad++; $display("FAIL redir_hs: got v=%b pc=%h instr=%h need v=1 pc=%h instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, e.pc, e.instr);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b need 0", bus.out_valid); end
    @(negedge clk);
    exp_q.push_back('{64'h70, 32'hf807801f});
    exp_q.push_back('{64'h74, 32'hb4000040});
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL redir_valid[%0d]: got %b need 1 (pending %0d)", i, bus.out_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          bad++; $display("FAIL redir_head[%0d]: got pc=%h instr=%h need pc=%h instr=%h", i, bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    // Misaligned target: low bits kept in the PC, dropped from the ROM address.
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h72;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (bus.imem_addr !== 7'd28) begin bad++; $display("FAIL unal_addr: got %0d need 28", bus.imem_addr); end
    @(negedge clk);
    exp_q.push_back('{64'h72, 32'hf807801f});
    exp_q.push_back('{64'h76, 32'hb4000040});
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL unal_valid[%0d]: got %b need 1 (pending %0d)", i, bus.out_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          bad++; $display("FAIL unal_head[%0d]: got pc=%h instr=%h need pc=%h instr=%h", i, bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 2; k++) begin
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = (k == 0) ? 64'h1fc : 64'hffff_ffff_ffff_fffc;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      total++; if (bus.imem_addr !== 7'd127) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d need 127", k, bus.imem_addr); end
      @(negedge clk);
      exp_q.delete();
      exp_q.push_back('{bus.redirect_pc, 32'h00000000});
      exp_q.push_back('{(k == 0) ? 64'h200 : 64'h0, 32'hf8000001});
      total++; if (bus.imem_addr !== 7'd0) begin bad++; $display("FAIL wrap_next_addr[%0d]: got %0d need 0", k, bus.imem_addr); end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
          bad++; $display("FAIL wrap_valid[%0d.%0d]: got %b need 1 (pending %0d)", k, i, bus.out_valid, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          total++;
          if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
            bad++; $display("FAIL wrap_head[%0d.%0d]: got pc=%h instr=%h need pc=%h instr=%h", k, i, bus.out_pc, bus.out_instr, e.pc, e.instr);
          end
        end
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_halt();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hb8;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL halt_pre: got v=%b h=%b need v=0 h=0", bus.out_valid, bus.halted);
    end
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back('{64'hb8, 32'hb400001f});
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
      bad++; $display("FAIL halt_head: got v=%b pc=%h instr=%h need v=1 pc=%h instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, e.pc, e.instr);
    end
    total++; if (bus.halted !== c_HALT_ON) begin bad++; $display("FAIL halt_flag: got %b need %b", bus.halted, c_HALT_ON); end
    @(negedge clk);
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1) begin
        bad++; $display("FAIL halt_hold[%0d]: got v=%b h=%b need v=0 h=1", i, bus.out_valid, bus.halted);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_clear: got %b need 0", bus.halted); end
    @(negedge clk);
    exp_q.push_back('{64'h0, 32'hf8000001});
`else
    exp_q.push_back('{64'hbc, rom(7'd47)});
`endif
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== e.pc || bus.out_instr !== e.instr || bus.halted !== 1'b0) begin
      bad++; $display("FAIL halt_after: got v=%b pc=%h instr=%h h=%b need v=1 pc=%h instr=%h h=0", bus.out_valid, bus.out_pc, bus.out_instr, bus.halted, e.pc, e.instr);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hb4;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'hb4 || bus.halted !== c_HALT_ON) begin
      bad++; $display("FAIL mid_pre: got v=%b pc=%h h=%b need v=1 pc=b4 h=%b", bus.out_valid, bus.out_pc, bus.halted, c_HALT_ON);
    end
    // Reset must win over a simultaneous redirect and handshake.
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h70;
    @(negedge clk);
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL mid_rst: got v=%b h=%b need v=0 h=0", bus.out_valid, bus.halted);
    end
    total++; if (bus.imem_addr !== 7'd0) begin bad++; $display("FAIL mid_addr: got %0d need 0", bus.imem_addr); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'hf8000001) begin
      bad++; $display("FAIL mid_restart: got v=%b pc=%h instr=%h need v=1 pc=0 instr=f8000001", bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
